// File: rtl/l2_resp_demux2_pkg.sv
// Shared types for the L2 response demux: the per-transaction channel selector.
package l2_resp_pkg;

    typedef logic ch_sel_t;

    localparam ch_sel_t CH0_SEL = 1'b0;
    localparam ch_sel_t CH1_SEL = 1'b1;

endpackage

// File: rtl/l2_resp_sel_fifo.sv
// Channel-order FIFO: remembers which channel won each accepted request, oldest first.
// Push and pop legality is decided by the instantiating block.
module l2_resp_sel_fifo
    import l2_resp_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  ch_sel_t          din_i,
    input  logic             pop_i,
    output ch_sel_t          dout_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    ch_sel_t          mem_q [DEPTH];
    ch_sel_t          mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_i) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/l2_resp_demux2.sv
// Steers in-order L2 bank response beats back to the granted channel (CH0/CH1).
// Define L2_RESP_DEMUX_OUT_REG_EN to register the response outputs (+1 cycle latency).
module l2_resp_demux2
    import l2_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned TAG_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH        = 20,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  gnt_CH0_i,
    input  logic                  gnt_CH1_i,
    output logic                  full_o,
    input  logic                  r_valid_i,
    input  logic [DATA_WIDTH-1:0] r_rdata_i,
    input  logic [TAG_WIDTH-1:0]  r_rtag_i,
    input  logic [ID_WIDTH-1:0]   r_ID_i,
    output logic                  r_valid_CH0_o,
    output logic                  r_valid_CH1_o,
    output logic [DATA_WIDTH-1:0] r_rdata_o,
    output logic [TAG_WIDTH-1:0]  r_rtag_o,
    output logic [ID_WIDTH-1:0]   r_ID_o,
    output logic                  err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic             push_req, push_en, pop_en;
    logic             route_ch0, route_ch1;
    ch_sel_t          sel_in, head_sel;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic             err_q, err_d;

    // CH0 wins a double grant; the CH1 grant is flagged as an error and dropped.
    assign push_req = gnt_CH0_i | gnt_CH1_i;
    assign sel_in   = gnt_CH0_i ? CH0_SEL : CH1_SEL;
    assign pop_en   = r_valid_i & ~fifo_empty;
    assign push_en  = push_req & (~fifo_full | pop_en);

    l2_resp_sel_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_sel_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_en),
        .din_i   (sel_in),
        .pop_i   (pop_en),
        .dout_o  (head_sel),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign route_ch0 = pop_en & (head_sel == CH0_SEL);
    assign route_ch1 = pop_en & (head_sel == CH1_SEL);

    always_comb begin
        err_d = err_q;
        if (push_req & fifo_full & ~pop_en)    err_d = 1'b1;
        if (gnt_CH0_i & gnt_CH1_i)             err_d = 1'b1;
        if (r_valid_i & (fifo_count == '0))    err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_o  = err_q;
    assign full_o = fifo_full;

`ifdef L2_RESP_DEMUX_OUT_REG_EN
    logic                  valid_ch0_q, valid_ch0_d;
    logic                  valid_ch1_q, valid_ch1_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [TAG_WIDTH-1:0]  rtag_q, rtag_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;

    // Data registers hold the last routed beat; dropped beats never load.
    always_comb begin
        valid_ch0_d = route_ch0;
        valid_ch1_d = route_ch1;
        rdata_d     = rdata_q;
        rtag_d      = rtag_q;
        id_d        = id_q;
        if (pop_en) begin
            rdata_d = r_rdata_i;
            rtag_d  = r_rtag_i;
            id_d    = r_ID_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_ch0_q <= 1'b0;
            valid_ch1_q <= 1'b0;
            rdata_q     <= '0;
            rtag_q      <= '0;
            id_q        <= '0;
        end else begin
            valid_ch0_q <= valid_ch0_d;
            valid_ch1_q <= valid_ch1_d;
            rdata_q     <= rdata_d;
            rtag_q      <= rtag_d;
            id_q        <= id_d;
        end
    end

    assign r_valid_CH0_o = valid_ch0_q;
    assign r_valid_CH1_o = valid_ch1_q;
    assign r_rdata_o     = rdata_q;
    assign r_rtag_o      = rtag_q;
    assign r_ID_o        = id_q;
`else
    assign r_valid_CH0_o = route_ch0;
    assign r_valid_CH1_o = route_ch1;
    assign r_rdata_o     = r_rdata_i;
    assign r_rtag_o      = r_rtag_i;
    assign r_ID_o        = r_ID_i;
`endif

endmodule

// File: tb/tb_l2_resp_demux2.sv
// Bench for l2_resp_demux2: directed scenarios plus randomized traffic against a queue model.
// Follows L2_RESP_DEMUX_OUT_REG_EN to expect the registered-output timing.
module tb_l2_resp_demux2;

    localparam int DW = 64;
    localparam int TW = 8;
    localparam int IW = 20;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          gnt_CH0_i, gnt_CH1_i, r_valid_i;
    logic [DW-1:0] r_rdata_i;
    logic [TW-1:0] r_rtag_i;
    logic [IW-1:0] r_ID_i;
    logic          full_o, r_valid_CH0_o, r_valid_CH1_o, err_o;
    logic [DW-1:0] r_rdata_o;
    logic [TW-1:0] r_rtag_o;
    logic [IW-1:0] r_ID_o;

    always #5 clk = ~clk;

    l2_resp_demux2 #(
        .DATA_WIDTH      (DW),
        .TAG_WIDTH       (TW),
        .ID_WIDTH        (IW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .gnt_CH0_i     (gnt_CH0_i),
        .gnt_CH1_i     (gnt_CH1_i),
        .full_o        (full_o),
        .r_valid_i     (r_valid_i),
        .r_rdata_i     (r_rdata_i),
        .r_rtag_i      (r_rtag_i),
        .r_ID_i        (r_ID_i),
        .r_valid_CH0_o (r_valid_CH0_o),
        .r_valid_CH1_o (r_valid_CH1_o),
        .r_rdata_o     (r_rdata_o),
        .r_rtag_o      (r_rtag_o),
        .r_ID_o        (r_ID_o),
        .err_o         (err_o)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: ordered list of granting channels plus a sticky error bit.
    int            ord_q[$];
    bit            m_err;
    bit            rv0_r, rv1_r;
    logic [DW-1:0] rd_r;
    logic [TW-1:0] rt_r;
    logic [IW-1:0] ri_r;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        gnt_CH0_i = 1'b0;
        gnt_CH1_i = 1'b0;
        r_valid_i = 1'b0;
        r_rdata_i = '0;
        r_rtag_i  = '0;
        r_ID_i    = '0;
    endtask

    task automatic model_clear();
        ord_q.delete();
        m_err = 1'b0;
        rv0_r = 1'b0;
        rv1_r = 1'b0;
        rd_r  = '0;
        rt_r  = '0;
        ri_r  = '0;
    endtask

    // Called at posedge+1: asserts reset asynchronously, checks the immediate effect, releases.
    task automatic do_reset(input string tag);
        idle_inputs();
        rst_n = 1'b0;
        #2;
        model_clear();
        chk({tag, "_full"}, 64'(full_o), 64'd0);
        chk({tag, "_err"}, 64'(err_o), 64'd0);
        chk({tag, "_v0"}, 64'(r_valid_CH0_o), 64'd0);
        chk({tag, "_v1"}, 64'(r_valid_CH1_o), 64'd0);
`ifdef L2_RESP_DEMUX_OUT_REG_EN
        chk({tag, "_rdata"}, r_rdata_o, 64'd0);
        chk({tag, "_rtag"}, 64'(r_rtag_o), 64'd0);
        chk({tag, "_id"}, 64'(r_ID_o), 64'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One bus cycle: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic step(input string tag, input bit g0, input bit g1, input bit rv,
                        input logic [DW-1:0] d, input logic [TW-1:0] t, input logic [IW-1:0] id);
        bit has, e0, e1;
        gnt_CH0_i = g0;
        gnt_CH1_i = g1;
        r_valid_i = rv;
        r_rdata_i = d;
        r_rtag_i  = t;
        r_ID_i    = id;
        @(negedge clk);
        has = (ord_q.size() != 0);
        e0  = rv && has && (ord_q[0] == 0);
        e1  = rv && has && (ord_q[0] == 1);
`ifdef L2_RESP_DEMUX_OUT_REG_EN
        chk({tag, "_v0"}, 64'(r_valid_CH0_o), 64'(rv0_r));
        chk({tag, "_v1"}, 64'(r_valid_CH1_o), 64'(rv1_r));
        chk({tag, "_rdata"}, r_rdata_o, rd_r);
        chk({tag, "_rtag"}, 64'(r_rtag_o), 64'(rt_r));
        chk({tag, "_id"}, 64'(r_ID_o), 64'(ri_r));
`else
        chk({tag, "_v0"}, 64'(r_valid_CH0_o), 64'(e0));
        chk({tag, "_v1"}, 64'(r_valid_CH1_o), 64'(e1));
        chk({tag, "_rdata"}, r_rdata_o, d);
        chk({tag, "_rtag"}, 64'(r_rtag_o), 64'(t));
        chk({tag, "_id"}, 64'(r_ID_o), 64'(id));
`endif
        chk({tag, "_full"}, 64'(full_o), 64'(ord_q.size() == MO));
        chk({tag, "_err"}, 64'(err_o), 64'(m_err));
        @(posedge clk);
        if (rv && !has) m_err = 1'b1;
        if (g0 && g1)   m_err = 1'b1;
        if (rv && has) void'(ord_q.pop_front());
        if (g0 || g1) begin
            if (ord_q.size() == MO) m_err = 1'b1;
            else ord_q.push_back(g0 ? 0 : 1);
        end
        rv0_r = e0;
        rv1_r = e1;
        if (e0 || e1) begin
            rd_r = d;
            rt_r = t;
            ri_r = id;
        end
        #1;
    endtask

    initial begin
        bit            g0, g1, rv;
        int            sel;
        logic [DW-1:0] d;

        idle_inputs();
        model_clear();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset("rst0");

        // In-order routing: grants CH0, CH1, CH0; responses A, B, C.
        step("t1_c1", 1, 0, 0, 64'h0, 8'h0, 20'h0);
        step("t1_c2", 0, 1, 0, 64'h0, 8'h0, 20'h0);
        step("t1_c3", 1, 0, 1, 64'hA, 8'h1, 20'h11);
        step("t1_c4", 0, 0, 1, 64'hB, 8'h2, 20'h22);
        step("t1_c5", 0, 0, 1, 64'hC, 8'h3, 20'h33);
        step("t1_c6", 0, 0, 0, 64'h0, 8'h0, 20'h0);
        step("t1_c7", 0, 0, 0, 64'h0, 8'h0, 20'h0);

        // Fill to MAX_OUTSTANDING, then simultaneous push and pop at full.
        do_reset("rst2");
        for (int i = 0; i < MO; i++) step("t2_fill", 0, 1, 0, 64'h0, 8'h0, 20'h0);
        step("t2_pp", 0, 1, 1, 64'h55, 8'h5, 20'h5);
        step("t2_chk", 0, 0, 0, 64'h0, 8'h0, 20'h0);

        // Push while full is dropped; drained responses all belong to CH1.
        step("t3_drop", 0, 1, 0, 64'h0, 8'h0, 20'h0);
        for (int i = 0; i < MO; i++) step("t3_drain", 0, 0, 1, 64'(i + 'h100), 8'(i), 20'(i));
        step("t3_post", 0, 0, 0, 64'h0, 8'h0, 20'h0);
        step("t3_post2", 0, 0, 0, 64'h0, 8'h0, 20'h0);

        // Response into an empty FIFO.
        do_reset("rst4");
        step("t4_empty", 0, 0, 1, 64'hDEAD, 8'h7, 20'h7);
        step("t4_post", 0, 0, 0, 64'h0, 8'h0, 20'h0);
        step("t4_post2", 0, 0, 0, 64'h0, 8'h0, 20'h0);

        // Double grant: CH0 kept, CH1 discarded.
        do_reset("rstdg");
        step("dg_gnt", 1, 1, 0, 64'h0, 8'h0, 20'h0);
        step("dg_rsp", 0, 0, 1, 64'hBEEF, 8'h9, 20'h9);
        step("dg_rsp2", 0, 0, 1, 64'hF00D, 8'hA, 20'hA);
        step("dg_post", 0, 0, 0, 64'h0, 8'h0, 20'h0);

        // Reset with three outstanding entries; the next response is an error.
        do_reset("rst5a");
        for (int i = 0; i < 3; i++) step("t5_gnt", 1, 0, 0, 64'h0, 8'h0, 20'h0);
        do_reset("rst5b");
        step("t5_rsp", 0, 0, 1, 64'h1234, 8'h4, 20'h4);
        step("t5_post", 0, 0, 0, 64'h0, 8'h0, 20'h0);

        // Randomized legal traffic: err must stay clear throughout.
        do_reset("rstr");
        for (int i = 0; i < 400; i++) begin
            rv  = (ord_q.size() != 0) && ($urandom_range(0, 2) != 0);
            sel = int'($urandom_range(0, 2));
            if (ord_q.size() == MO && !rv) sel = 0;
            g0  = (sel == 1);
            g1  = (sel == 2);
            d   = {$urandom, $urandom};
            step("rnd", g0, g1, rv, d, 8'($urandom), 20'($urandom));
        end
        // Unconstrained random traffic, including protocol violations.
        for (int i = 0; i < 150; i++) begin
            d = {$urandom, $urandom};
            step("rndx", 1'($urandom), 1'($urandom), 1'($urandom), d, 8'($urandom), 20'($urandom));
        end
        step("end", 0, 0, 0, 64'h0, 8'h0, 20'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
